// File: rtl/io_input_reg_pkg.sv
// Shared IO address table and read-select decode for the MEM-stage IO bus.
// Latency: n/a (constants and a pure decode function).
// Backpressure: none; the IO bus has no stall path.
//
// Holds the word addresses (addr[7:2]) of both IO blocks so the output
// register and the input register decode from one table.
package io_input_reg_pkg;

  // Output register word addresses (0x80, 0x84, 0x88)
  localparam logic [5:0] IO_OUT0_ADDR = 6'b100000;
  localparam logic [5:0] IO_OUT1_ADDR = 6'b100001;
  localparam logic [5:0] IO_OUT2_ADDR = 6'b100010;

  // Input register word addresses (0xC0, 0xC4, 0xC8, 0xCC)
  localparam logic [5:0] IO_IN0_ADDR  = 6'b110000;
  localparam logic [5:0] IO_IN1_ADDR  = 6'b110001;
  localparam logic [5:0] IO_IN2_ADDR  = 6'b110010;
  localparam logic [5:0] IO_STAT_ADDR = 6'b110011;

  localparam int IO_NUM_IN_PORTS = 3;

  // Which register (if any) a read address selects
  typedef enum logic [2:0] {
    RSEL_NONE,
    RSEL_OUT,   // belongs to the output register, this block returns 0
    RSEL_IN0,
    RSEL_IN1,
    RSEL_IN2,
    RSEL_STAT
  } io_rsel_e;

  function automatic io_rsel_e io_decode_rd(input logic [5:0] word_addr);
    case (word_addr)
      IO_OUT0_ADDR, IO_OUT1_ADDR, IO_OUT2_ADDR: return RSEL_OUT;
      IO_IN0_ADDR:                              return RSEL_IN0;
      IO_IN1_ADDR:                              return RSEL_IN1;
      IO_IN2_ADDR:                              return RSEL_IN2;
      IO_STAT_ADDR:                             return RSEL_STAT;
      default:                                  return RSEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_input_reg_if.sv
// CPU-side IO read bus: byte address, read strobe and returned read data.
// Latency: dataout is combinational from the slave's registered state.
// Backpressure: none; every read completes in the cycle it is issued.
//
// master: CPU MEM stage (drives addr/read_io_enable, samples dataout)
// slave : IO input register (decodes addr, returns dataout)
interface io_input_reg_if;

  logic [31:0] addr;            // CPU byte address, only [7:2] decoded
  logic        read_io_enable;  // IO read strobe, qualifies clear-on-read
  logic [31:0] dataout;         // read data

  modport master (
    output addr,
    output read_io_enable,
    input  dataout
  );

  modport slave (
    input  addr,
    input  read_io_enable,
    output dataout
  );

endinterface

// File: rtl/io_input_reg_debounce.sv
// One input port: 2-flop synchroniser, optional debounce, accepted (stable) value.
// Latency: input reaches o_stable on edge 3 (no debounce) or edge 3+DEBOUNCE_CYCLES.
// Backpressure: none; the port samples every edge.
//
// Ports:
//   i_clk     clock, all state on rising edge
//   i_rst     asynchronous active-high reset
//   i_in      asynchronous 32-bit external input
//   o_stable  currently accepted value
//   o_change  high in the cycle whose closing edge loads a new o_stable
// Build option: IO_INPUT_DEBOUNCE_EN enables the debounce counter.
module io_input_reg_debounce
`ifdef IO_INPUT_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
)
`endif
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_in,
  output logic [31:0] o_stable,
  output logic        o_change
);

  logic [31:0] r_s1;
  logic [31:0] r_s2;
  logic [31:0] r_stable;
  logic        w_upd;

`ifdef IO_INPUT_DEBOUNCE_EN

  logic [31:0]      r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cond;

  // A candidate is a synchronised value that differs from the accepted one
  // and did not change since the previous edge; any bit flip drops w_cond
  // and so restarts the count.
  assign w_cond = (r_s2 != r_stable) && (r_s2 == r_prev);
  assign w_upd  = w_cond && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_s1   <= i_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      if (!w_cond) begin
        r_cnt <= '0;
      end else if (w_upd) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`else

  // Without debounce the accepted value simply follows the synchroniser.
  assign w_upd = (r_s2 != r_stable);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
    end else begin
      r_s1     <= i_in;
      r_s2     <= r_s1;
      r_stable <= r_s2;
    end
  end

`endif

  assign o_stable = r_stable;
  assign o_change = w_upd;

endmodule

// File: rtl/io_input_reg.sv
// Memory-mapped input-port block: three synchronised/debounced 32-bit ports plus sticky change flags.
// Latency: reads are combinational from registered state; inputs visible on edge 3 (+DEBOUNCE_CYCLES).
// Backpressure: none; reads always complete, inputs are sampled every edge.
//
// Ports:
//   i_io_clk     sole clock
//   i_clr        asynchronous active-high reset
//   i_in_port0-2 asynchronous external inputs (switches/keys)
//   io_bus       CPU IO read bus (slave): addr, read_io_enable -> dataout
// Read map (addr[7:2]): 0xC0/0xC4/0xC8 stable port value, 0xCC {29'b0, changed[2:0]},
// everything else reads 0. A strobed read of 0xCC clears changed[]; a flag set on the
// same edge survives.
// Build option: IO_INPUT_DEBOUNCE_EN enables per-port debounce counters.
module io_input_reg
  import io_input_reg_pkg::*;
`ifdef IO_INPUT_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
)
`endif
(
  input  logic         i_io_clk,
  input  logic         i_clr,
  input  logic [31:0]  i_in_port0,
  input  logic [31:0]  i_in_port1,
  input  logic [31:0]  i_in_port2,
  io_input_reg_if.slave io_bus
);

  logic [31:0]                w_in     [IO_NUM_IN_PORTS];
  logic [31:0]                w_stable [IO_NUM_IN_PORTS];
  logic [IO_NUM_IN_PORTS-1:0] w_change;
  logic [IO_NUM_IN_PORTS-1:0] r_changed;
  io_rsel_e                   w_rsel;
  logic                       w_stat_clr;
  logic [31:0]                w_dataout;
  logic                       w_unused_addr_bits;

  assign w_in[0] = i_in_port0;
  assign w_in[1] = i_in_port1;
  assign w_in[2] = i_in_port2;

  for (genvar gi = 0; gi < IO_NUM_IN_PORTS; gi++) begin : g_port
    io_input_reg_debounce
`ifdef IO_INPUT_DEBOUNCE_EN
    #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    )
`endif
    u_debounce (
      .i_clk    (i_io_clk),
      .i_rst    (i_clr),
      .i_in     (w_in[gi]),
      .o_stable (w_stable[gi]),
      .o_change (w_change[gi])
    );
  end

  // Only the word index inside the IO page is decoded.
  assign w_rsel             = io_decode_rd(io_bus.addr[7:2]);
  assign w_unused_addr_bits = ^{io_bus.addr[31:8], io_bus.addr[1:0]};

  assign w_stat_clr = io_bus.read_io_enable && (w_rsel == RSEL_STAT);

  // Clear is applied first and new changes ORed on top, so a port that
  // qualifies on the same edge as a status read keeps its flag.
  always_ff @(posedge i_io_clk or posedge i_clr) begin
    if (i_clr) begin
      r_changed <= '0;
    end else begin
      r_changed <= (w_stat_clr ? '0 : r_changed) | w_change;
    end
  end

  always_comb begin
    w_dataout = '0;
    case (w_rsel)
      RSEL_IN0:  w_dataout = w_stable[0];
      RSEL_IN1:  w_dataout = w_stable[1];
      RSEL_IN2:  w_dataout = w_stable[2];
      RSEL_STAT: w_dataout = {29'b0, r_changed};
      default:   w_dataout = '0;
    endcase
  end

  assign io_bus.dataout = w_dataout;

endmodule

// File: tb/tb_io_input_reg.sv
module tb_io_input_reg;

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 0;
`endif
  // A value is accepted once the synchroniser output has held it on D+1 edges.
  localparam int HL = D + 2;

  logic        clk;
  logic        clr;
  logic [31:0] in_p [3];

  io_input_reg_if bus();

  io_input_reg dut (
    .i_io_clk   (clk),
    .i_clr      (clr),
    .i_in_port0 (in_p[0]),
    .i_in_port1 (in_p[1]),
    .i_in_port2 (in_p[2]),
    .io_bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: accepted values, sticky flags, and per-port history of
  // sampled inputs (index 0 = sampled on the latest edge).
  logic [31:0] m_stable [3];
  logic [2:0]  m_changed;
  logic [31:0] m_hist   [3][HL];

  task automatic m_reset();
    for (int p = 0; p < 3; p++) begin
      m_stable[p] = '0;
      for (int k = 0; k < HL; k++) m_hist[p][k] = '0;
    end
    m_changed = '0;
  endtask

  // The synchroniser shows the input sampled two edges ago; a new value is
  // taken when it has been seen unchanged on D+1 consecutive edges.
  function automatic bit m_will_update(int p);
    logic [31:0] x;
    x = m_hist[p][1];
    for (int k = 1; k < HL; k++) if (m_hist[p][k] !== x) return 1'b0;
    return (x !== m_stable[p]);
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    case (a[7:2])
      6'b110000: return m_stable[0];
      6'b110001: return m_stable[1];
      6'b110010: return m_stable[2];
      6'b110011: return {29'b0, m_changed};
      default:   return 32'h0;
    endcase
  endfunction

  // Advance one rising edge, update the model, return at the falling edge.
  task automatic step();
    logic [2:0] upd;
    @(posedge clk);
    if (!clr) begin
      upd = '0;
      for (int p = 0; p < 3; p++) upd[p] = m_will_update(p);
      for (int p = 0; p < 3; p++) if (upd[p]) m_stable[p] = m_hist[p][1];
      if (bus.read_io_enable && bus.addr[7:2] == 6'b110011) m_changed = upd;
      else m_changed = m_changed | upd;
      for (int p = 0; p < 3; p++) begin
        for (int k = HL - 1; k > 0; k--) m_hist[p][k] = m_hist[p][k-1];
        m_hist[p][0] = in_p[p];
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    clr = 1'b1;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
  endtask

  logic [31:0] addr_tab [4];
  initial begin
    addr_tab[0] = 32'hC0; addr_tab[1] = 32'hC4;
    addr_tab[2] = 32'hC8; addr_tab[3] = 32'hCC;
  end

  task automatic test_reset();
    in_p[0] = 32'hDEAD_BEEF; in_p[1] = 32'h1; in_p[2] = 32'h8000_0000;
    bus.read_io_enable = 1'b0;
    clr = 1'b1;
    m_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.addr = addr_tab[i];
      #1;
      checks++;
      if (bus.dataout !== 32'h0) begin
        failures++;
        $display("FAIL reset_read addr=%h got=%h exp=%h", bus.addr, bus.dataout, 32'h0);
      end
    end
    in_p[0] = '0; in_p[1] = '0; in_p[2] = '0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Input settles before edge 1; must appear on edge 3+D, with status 1.
  task automatic test_latency();
    clr = 1'b1;
    m_reset();
    in_p[0] = 32'hA5A5_0001;
    bus.addr = 32'hC0;
    @(negedge clk);
    clr = 1'b0;
    for (int n = 1; n <= D + 6; n++) begin
      step();
      bus.addr = 32'hC0;
      #1;
      checks++;
      if (bus.dataout !== ((n >= 3 + D) ? 32'hA5A5_0001 : 32'h0)) begin
        failures++;
        $display("FAIL latency edge=%0d got=%h exp=%h", n, bus.dataout,
                 (n >= 3 + D) ? 32'hA5A5_0001 : 32'h0);
      end
    end
    bus.addr = 32'hCC;
    #1;
    checks++;
    if (bus.dataout !== 32'h1) begin
      failures++;
      $display("FAIL latency_status got=%h exp=%h", bus.dataout, 32'h1);
    end
  endtask

  task automatic test_glitch();
    in_p[1] = 32'hFF;
    step();
    step();
    in_p[1] = 32'h0;
    for (int n = 0; n < D + 6; n++) begin
      step();
      bus.addr = 32'hC4;
      #1;
      checks++;
      if (bus.dataout !== m_read(32'hC4)) begin
        failures++;
        $display("FAIL glitch_data n=%0d got=%h exp=%h", n, bus.dataout, m_read(32'hC4));
      end
      bus.addr = 32'hCC;
      #1;
      checks++;
      if (bus.dataout[1] !== m_changed[1]) begin
        failures++;
        $display("FAIL glitch_flag n=%0d got=%b exp=%b", n, bus.dataout[1], m_changed[1]);
      end
    end
  endtask

  task automatic test_clear_race();
    bit found;
    bus.addr = 32'hCC;
    bus.read_io_enable = 1'b1;
    step();
    bus.read_io_enable = 1'b0;
    #1;
    checks++;
    if (bus.dataout !== m_read(32'hCC)) begin
      failures++;
      $display("FAIL race_preclear got=%h exp=%h", bus.dataout, m_read(32'hCC));
    end
    in_p[2] = $urandom | 32'h1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (m_will_update(2)) begin
        bus.addr = 32'hCC;
        bus.read_io_enable = 1'b1;
        step();
        bus.read_io_enable = 1'b0;
        #1;
        found = 1'b1;
        checks++;
        if (bus.dataout[2] !== 1'b1) begin
          failures++;
          $display("FAIL race_set_wins got=%b exp=%b", bus.dataout[2], 1'b1);
        end
      end else begin
        step();
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL race_timeout got=no_qualify exp=qualify_within_20");
    end
    bus.addr = 32'hCC;
    bus.read_io_enable = 1'b1;
    step();
    bus.read_io_enable = 1'b0;
    #1;
    checks++;
    if (bus.dataout !== 32'h0) begin
      failures++;
      $display("FAIL race_cleared got=%h exp=%h", bus.dataout, 32'h0);
    end
  endtask

  task automatic test_decode();
    logic [31:0] stat_before;
    in_p[0] = $urandom | 32'h1;
    in_p[1] = $urandom | 32'h2;
    for (int n = 0; n < D + 4; n++) step();
    bus.addr = 32'h80;
    #1;
    checks++;
    if (bus.dataout !== 32'h0) begin
      failures++;
      $display("FAIL decode_0x80 got=%h exp=%h", bus.dataout, 32'h0);
    end
    bus.addr = 32'hD0;
    #1;
    checks++;
    if (bus.dataout !== 32'h0) begin
      failures++;
      $display("FAIL decode_0xD0 got=%h exp=%h", bus.dataout, 32'h0);
    end
    stat_before = m_read(32'hCC);
    for (int n = 0; n < 3; n++) begin
      bus.addr = 32'hC4;
      bus.read_io_enable = 1'b1;
      step();
      #1;
      checks++;
      if (bus.dataout !== in_p[1]) begin
        failures++;
        $display("FAIL decode_c4_data got=%h exp=%h", bus.dataout, in_p[1]);
      end
    end
    bus.read_io_enable = 1'b0;
    bus.addr = 32'hCC;
    #1;
    checks++;
    if (bus.dataout !== stat_before) begin
      failures++;
      $display("FAIL decode_status_kept got=%h exp=%h", bus.dataout, stat_before);
    end
  endtask

  task automatic test_random();
    int          hold [3];
    logic [31:0] r;
    for (int p = 0; p < 3; p++) hold[p] = 0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        bus.addr = addr_tab[i];
        #1;
        checks++;
        if (bus.dataout !== m_read(addr_tab[i])) begin
          failures++;
          $display("FAIL random n=%0d addr=%h got=%h exp=%h", n, addr_tab[i],
                   bus.dataout, m_read(addr_tab[i]));
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (hold[p] == 0) begin
          in_p[p] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
          hold[p] = $urandom_range(1, 2 * D + 3);
        end
        hold[p]--;
      end
      r = $urandom;
      case ($urandom_range(0, 5))
        0:       bus.addr = {r[31:8], 8'hC0};
        1:       bus.addr = {r[31:8], 8'hC4};
        2:       bus.addr = {r[31:8], 8'hC8};
        3:       bus.addr = {r[31:8], 8'hCC};
        4:       bus.addr = 32'h80;
        default: bus.addr = r;
      endcase
      bus.read_io_enable = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.read_io_enable = 1'b0;
  endtask

  // Reset in the middle of qualifying a new value: zero at once, then the
  // value must re-qualify from scratch after release.
  task automatic test_reset_midcount();
    in_p[0] = 32'h0F0F_1234;
    if (m_stable[0] === 32'h0F0F_1234) in_p[0] = 32'h0F0F_4321;
    for (int n = 0; n < 4; n++) step();
    #2;
    clr = 1'b1;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      bus.addr = addr_tab[i];
      #1;
      checks++;
      if (bus.dataout !== 32'h0) begin
        failures++;
        $display("FAIL midrun_reset addr=%h got=%h exp=%h", bus.addr, bus.dataout, 32'h0);
      end
    end
    @(negedge clk);
    clr = 1'b0;
    for (int n = 1; n <= D + 5; n++) begin
      step();
      bus.addr = 32'hC0;
      #1;
      checks++;
      if (bus.dataout !== ((n >= 3 + D) ? in_p[0] : 32'h0)) begin
        failures++;
        $display("FAIL requalify edge=%0d got=%h exp=%h", n, bus.dataout,
                 (n >= 3 + D) ? in_p[0] : 32'h0);
      end
    end
  endtask

  initial begin
    clr = 1'b1;
    bus.addr = '0;
    bus.read_io_enable = 1'b0;
    in_p[0] = '0; in_p[1] = '0; in_p[2] = '0;
    m_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_clear_race();
    test_decode();
    test_random();
    test_reset_midcount();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
